// File: rtl/pat_det_ctrl.sv
// Run controller for a bit-serial pattern detector: arm, count matches, stop at target.
// Define PAT_DET_POS_TRACK_EN to add a bit-position counter and the last_pos output.
module pat_det_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
`ifdef PAT_DET_POS_TRACK_EN
  output logic [15:0]      last_pos,
`endif
  output logic             cfg_err
);

  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [PAT_W-1:0]   pattern_reg, pattern_next;
  logic               overlap_reg, overlap_next;
  logic [CNT_W-1:0]   target_reg, target_next;
  logic [PAT_W-2:0]   hist_reg, hist_next;
  logic [FILL_W-1:0]  fill_reg, fill_next;
  logic               match_reg, match_next;
  logic [CNT_W-1:0]   match_cnt_reg, match_cnt_next;
  logic               cfg_err_reg, cfg_err_next;
  logic [PAT_W-1:0]   sample;

`ifdef PAT_DET_POS_TRACK_EN
  logic [15:0] bit_pos_reg, bit_pos_next;
  logic [15:0] last_pos_reg, last_pos_next;
`endif

  // Window including the bit on the wire this cycle; used for the Mealy match test.
  assign sample = {hist_reg, in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      pattern_reg   <= '0;
      overlap_reg   <= 1'b1;
      target_reg    <= '0;
      hist_reg      <= '0;
      fill_reg      <= '0;
      match_reg     <= 1'b0;
      match_cnt_reg <= '0;
      cfg_err_reg   <= 1'b0;
`ifdef PAT_DET_POS_TRACK_EN
      bit_pos_reg   <= '0;
      last_pos_reg  <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      pattern_reg   <= pattern_next;
      overlap_reg   <= overlap_next;
      target_reg    <= target_next;
      hist_reg      <= hist_next;
      fill_reg      <= fill_next;
      match_reg     <= match_next;
      match_cnt_reg <= match_cnt_next;
      cfg_err_reg   <= cfg_err_next;
`ifdef PAT_DET_POS_TRACK_EN
      bit_pos_reg   <= bit_pos_next;
      last_pos_reg  <= last_pos_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    pattern_next   = pattern_reg;
    overlap_next   = overlap_reg;
    target_next    = target_reg;
    hist_next      = hist_reg;
    fill_next      = fill_reg;
    match_next     = 1'b0;
    match_cnt_next = match_cnt_reg;
    cfg_err_next   = 1'b0;
`ifdef PAT_DET_POS_TRACK_EN
    bit_pos_next   = bit_pos_reg;
    last_pos_next  = last_pos_reg;
`endif

    case (state_reg)
      ST_ARMED: begin
        cfg_err_next = cfg_we;
        // Abort wins over a sample completing in the same cycle.
        if (abort) begin
          state_next = ST_IDLE;
        end else if (in_valid) begin
          hist_next = sample[PAT_W-2:0];
          if (fill_reg != FILL_MAX) fill_next = fill_reg + 1'b1;
`ifdef PAT_DET_POS_TRACK_EN
          if (bit_pos_reg != 16'hFFFF) bit_pos_next = bit_pos_reg + 16'd1;
`endif
          if (fill_reg == FILL_MAX && sample == pattern_reg) begin
            match_next     = 1'b1;
            match_cnt_next = match_cnt_reg + 1'b1;
`ifdef PAT_DET_POS_TRACK_EN
            last_pos_next  = bit_pos_next;
`endif
            if (!overlap_reg) fill_next = '0;
            if (target_reg != '0 && match_cnt_next == target_reg) state_next = ST_DONE;
          end
        end
      end
      default: begin
        if (cfg_we) begin
          pattern_next = cfg_pattern;
          overlap_next = cfg_overlap;
          target_next  = cfg_target;
        end
        if (abort) begin
          state_next = ST_IDLE;
        end else if (start) begin
          state_next     = ST_ARMED;
          hist_next      = '0;
          fill_next      = '0;
          match_cnt_next = '0;
`ifdef PAT_DET_POS_TRACK_EN
          bit_pos_next   = '0;
`endif
        end
      end
    endcase
  end

  assign busy      = (state_reg == ST_ARMED);
  assign done      = (state_reg == ST_DONE);
  assign match     = match_reg;
  assign match_cnt = match_cnt_reg;
  assign cfg_err   = cfg_err_reg;
`ifdef PAT_DET_POS_TRACK_EN
  assign last_pos  = last_pos_reg;
`endif

endmodule
